// File: rtl/pueo_trig_rx.sv
// rtl/pueo_trig_rx.sv - TURF trigger-word receiver: frame lock, framing/sequence check, FIFO, error counters (option: PUEO_TRIG_RX_SEQCHECK_EN)
module pueo_trig_rx #(
    parameter int FIFO_DEPTH   = 16,
    parameter int SAMPLE_PHASE = 4
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rstn_i,
    input  logic        sysclk_phase_i,
    input  logic [11:0] turf_trig_i,
    input  logic [7:0]  turf_metadata_i,
    input  logic        turf_valid_i,
    output logic [19:0] m_tdata_o,
    output logic        m_tvalid_o,
    input  logic        m_tready_i,
    output logic        locked_o,
    output logic [15:0] seq_err_count_o,
    output logic [15:0] frame_err_count_o,
    output logic [15:0] ovf_count_o,
    input  logic        count_clear_i
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_UNLOCKED, ST_ALIGN, ST_LOCKED} state_t;
    state_t state_q, state_n;

    // cnt_q is the index the current cycle would have if no pulse arrives;
    // it wraps to 0 exactly 8 cycles after a pulse.
    logic [2:0]  cnt_q, cyc;
    logic        gap_ovf_q;
    logic        lose_early, lose_missing, chk_en;
    logic        ref_q, viol, frame_bad_q, frame_bad_eff, new_viol;
    logic        cap_q, push, push_ok, pop, full;
    logic [19:0] word_q;
    logic [19:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [15:0]   frame_err_q, ovf_q;

    assign cyc          = sysclk_phase_i ? 3'd0 : cnt_q;
    assign chk_en       = (state_q == ST_LOCKED);
    assign lose_early   = chk_en && sysclk_phase_i && (cnt_q != 3'd0);
    assign lose_missing = chk_en && !sysclk_phase_i && (cnt_q == 3'd0);

    function automatic logic [15:0] sat_next(input logic [15:0] c, input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction

    // Phase counter and "spacing exceeded 8" flag used while aligning
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            cnt_q     <= 3'd0;
            gap_ovf_q <= 1'b0;
        end else begin
            cnt_q <= cyc + 3'd1;
            if (sysclk_phase_i)
                gap_ovf_q <= 1'b0;
            else if (cnt_q == 3'd0)
                gap_ovf_q <= 1'b1;
        end
    end

    // Lock state register
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) state_q <= ST_UNLOCKED;
        else                state_q <= state_n;
    end

    // Lock next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_UNLOCKED: if (sysclk_phase_i) state_n = ST_ALIGN;
            ST_ALIGN:    if (sysclk_phase_i && cnt_q == 3'd0 && !gap_ovf_q) state_n = ST_LOCKED;
            ST_LOCKED:   if (lose_early || lose_missing) state_n = ST_UNLOCKED;
            default:     state_n = ST_UNLOCKED;
        endcase
    end

    assign locked_o = chk_en;

    // Framing violation: valid must match its cycle-3 value through cycle 6 and be low elsewhere
    always_comb begin
        viol = 1'b0;
        if (cyc == 3'd3)
            viol = 1'b0;
        else if (cyc >= 3'd4 && cyc <= 3'd6)
            viol = (turf_valid_i != ref_q);
        else
            viol = turf_valid_i;
    end

    assign frame_bad_eff = (cyc == 3'd0) ? 1'b0 : frame_bad_q;
    assign new_viol      = chk_en && viol && !frame_bad_eff;
    assign push          = chk_en && (cyc == 3'd7) && cap_q && !frame_bad_eff && !viol;

    // Per-frame framing state and word capture at the sample phase
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            ref_q       <= 1'b0;
            frame_bad_q <= 1'b0;
            cap_q       <= 1'b0;
            word_q      <= 20'd0;
        end else begin
            if (cyc == 3'd3) ref_q <= turf_valid_i;
            frame_bad_q <= chk_en && (frame_bad_eff || viol);
            if (!chk_en || cyc == 3'd0)
                cap_q <= 1'b0;
            else if (cyc == 3'(SAMPLE_PHASE) && turf_valid_i && !frame_bad_eff && !viol) begin
                cap_q  <= 1'b1;
                word_q <= {turf_metadata_i, turf_trig_i};
            end
        end
    end

`ifdef PUEO_TRIG_RX_SEQCHECK_EN
    logic       seed_q, seq_inc;
    logic [6:0] exp_q;
    logic [15:0] seq_err_q;

    assign seq_inc = push && seed_q && (word_q[18:12] != exp_q);

    // Expected sequence number; reseeded from every accepted word, cleared on lock entry
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            seed_q <= 1'b0;
            exp_q  <= 7'd0;
        end else if (state_q != ST_LOCKED && state_n == ST_LOCKED) begin
            seed_q <= 1'b0;
        end else if (push) begin
            seed_q <= 1'b1;
            exp_q  <= word_q[18:12] + 7'd1;
        end
    end

    // Saturating sequence error counter
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i || count_clear_i) seq_err_q <= 16'd0;
        else                                 seq_err_q <= sat_next(seq_err_q, seq_inc);
    end
    assign seq_err_count_o = seq_err_q;
`else
    assign seq_err_count_o = 16'd0;
`endif

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = m_tvalid_o && m_tready_i;
    assign push_ok = push && (!full || pop);

    // FIFO storage
    always_ff @(posedge sysclk_i) begin
        if (push_ok) mem[wr_ptr_q] <= word_q;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign m_tvalid_o = (count_q != '0);
    assign m_tdata_o  = m_tvalid_o ? mem[rd_ptr_q] : 20'd0;

    // Saturating framing and overflow counters
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rstn_i || count_clear_i) begin
            frame_err_q <= 16'd0;
            ovf_q       <= 16'd0;
        end else begin
            frame_err_q <= sat_next(frame_err_q, new_viol || lose_early || lose_missing);
            ovf_q       <= sat_next(ovf_q, push && !push_ok);
        end
    end

    assign frame_err_count_o = frame_err_q;
    assign ovf_count_o       = ovf_q;
endmodule

// File: tb/tb_pueo_trig_rx.sv
// tb/tb_pueo_trig_rx.sv - scoreboard bench for pueo_trig_rx
module tb_pueo_trig_rx;
    logic        clk = 1'b0;
    logic        rstn, phase, valid, tready, clear;
    logic [11:0] trig;
    logic [7:0]  md;
    logic [19:0] tdata;
    logic        tvalid, locked;
    logic [15:0] seq_cnt, frm_cnt, ovf_cnt;

    always #5 clk = ~clk;

`ifdef PUEO_TRIG_RX_SEQCHECK_EN
    localparam int SEQ_EXP = 1;
`else
    localparam int SEQ_EXP = 0;
`endif

    pueo_trig_rx dut (
        .sysclk_i          (clk),
        .sysclk_rstn_i     (rstn),
        .sysclk_phase_i    (phase),
        .turf_trig_i       (trig),
        .turf_metadata_i   (md),
        .turf_valid_i      (valid),
        .m_tdata_o         (tdata),
        .m_tvalid_o        (tvalid),
        .m_tready_i        (tready),
        .locked_o          (locked),
        .seq_err_count_o   (seq_cnt),
        .frame_err_count_o (frm_cnt),
        .ovf_count_o       (ovf_cnt),
        .count_clear_i     (clear)
    );

    typedef struct {
        logic [19:0] d;
        int          t;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop expected words whenever the DUT hands one over
    always @(negedge clk) begin
        if (rstn && tvalid && tready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word actual=%0h required=none", tdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("tdata", tdata, e.d);
                if (e.t >= 0) chk("latency", cyc_n, e.t);
            end
        end
    end

    // One frame: optional pulse at cycle 0, valid over 3..6 except at cycle drop
    task automatic frame(input bit ph, input bit vld, input logic [7:0] m, input logic [11:0] a,
                         input int drop, input int len, input bit exp_push);
        for (int c = 0; c < len; c++) begin
            @(posedge clk);
            #1;
            phase = ph && (c == 0);
            valid = vld && (c >= 3) && (c <= 6) && (c != drop);
            md    = m;
            trig  = a;
            if (c == 0 && exp_push) begin
                exp_t e;
                e.d = {m, a};
                e.t = tready ? cyc_n + 8 : -1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        frame(1'b1, 1'b0, 8'h00, 12'h000, -1, 8, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rstn = 0; phase = 0; valid = 0; tready = 1; clear = 0; trig = '0; md = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_frm", frm_cnt, 0);
        chk("rst_ovf", ovf_cnt, 0);
        @(posedge clk);
        #1 rstn = 1;

        // lock acquisition
        idle();
        @(negedge clk);
        chk("align_not_locked", locked, 0);
        idle();
        idle();
        @(negedge clk);
        chk("locked", locked, 1);
        chk("lock_tvalid", tvalid, 0);
        chk("lock_frm", frm_cnt, 0);
        chk("lock_seq", seq_cnt, 0);

        // normal words and a sequence gap
        frame(1, 1, 8'h80, 12'h123, -1, 8, 1);
        frame(1, 1, 8'h81, 12'h456, -1, 8, 1);
        idle();
        idle();
        @(negedge clk);
        chk("seq_ok", seq_cnt, 0);
        frame(1, 1, 8'h83, 12'h789, -1, 8, 1);
        frame(1, 1, 8'h84, 12'hABC, -1, 8, 1);
        idle();
        idle();
        @(negedge clk);
        chk("seq_gap", seq_cnt, SEQ_EXP);

        // framing violation, then early pulse
        frame(1, 1, 8'h85, 12'h555, 5, 8, 0);
        @(negedge clk);
        chk("drop_frm", frm_cnt, 1);
        chk("drop_locked", locked, 1);
        frame(1, 0, 8'h00, 12'h000, -1, 7, 0);
        idle();
        @(negedge clk);
        chk("early_locked", locked, 0);
        chk("early_frm", frm_cnt, 2);
        idle();
        idle();
        @(negedge clk);
        chk("relocked", locked, 1);
        idle();

        // overflow with a stalled consumer
        tready = 0;
        for (int i = 0; i < 18; i++)
            frame(1, 1, 8'(i), 12'(12'h100 + i), -1, 8, i < 16);
        idle();
        @(negedge clk);
        chk("ovf_count", ovf_cnt, 2);
        chk("ovf_tvalid", tvalid, 1);
        @(posedge clk);
        #1 tready = 1;
        for (int k = 0; k < 100 && (sb.size() != 0 || tvalid); k++) @(posedge clk);
        @(negedge clk);
        chk("drain_tvalid", tvalid, 0);
        chk("drain_sb", sb.size(), 0);

        // reset mid-frame with words held
        tready = 0;
        for (int i = 0; i < 5; i++)
            frame(1, 1, 8'(8'h12 + i), 12'(12'h200 + i), -1, 8, 1);
        @(posedge clk);
        #1 phase = 1;
        @(posedge clk);
        #1 phase = 0;
        @(posedge clk);
        #1 rstn = 0;
        sb.delete();
        @(negedge clk);
        chk("pre_rst_tvalid", tvalid, 1);
        @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_seq", seq_cnt, 0);
        chk("mid_rst_frm", frm_cnt, 0);
        chk("mid_rst_ovf", ovf_cnt, 0);

        // counter clear
        tready = 1;
        idle();
        idle();
        idle();
        frame(1, 0, 8'h00, 12'h000, -1, 7, 0);
        idle();
        @(negedge clk);
        chk("clr_pre_frm", frm_cnt, 1);
        @(posedge clk);
        #1 clear = 1;
        @(posedge clk);
        #1 clear = 0;
        @(negedge clk);
        chk("clr_frm", frm_cnt, 0);

        chk("final_sb", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
